ieee_adder_pack: RTL

- Back end of the single-precision adder pipeline; the inverse of the unpack/align front stage.
- Takes the unnormalized sign/exponent/mantissa sum plus special-case flags, then normalizes, rounds (round-to-nearest-even), and packs an IEEE754 binary32 word.
- Two-stage pipeline with valid/ready handshake; stalls in place under downstream backpressure.

---
 rtl/ieee754_pkg.sv | 39 +++
 rtl/ieee_lzc27.sv | 23 ++
 rtl/ieee_adder_pack.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ieee754_pkg.sv
// ----------------------------------------------------------------------------
// ieee754_pkg: shared binary32 constants, mantissa bit map and result class.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package ieee754_pkg;

  localparam int          EXP_BIAS   = 127;
  localparam int          EXP_MAX    = 255;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam int          FRAC_W     = 23;
  localparam int          EXPF_W     = 8;

  // Bit positions inside the 28-bit unnormalized sum
  localparam int          CARRY_BIT  = 27;
  localparam int          HIDDEN_BIT = 26;
  localparam int          LSB_BIT    = 3;
  localparam int          G_BIT      = 2;
  localparam int          R_BIT      = 1;
  localparam int          S_BIT      = 0;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  function automatic logic [31:0] pack_fp(input logic              sign,
                                          input logic [EXPF_W-1:0] expf,
                                          input logic [FRAC_W-1:0] frac);
    return {sign, expf, frac};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ieee_lzc27.sv
// ----------------------------------------------------------------------------
// ieee_lzc27: combinational leading-zero count of a 27-bit word (27 if zero).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ieee_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ieee_adder_pack.sv
// ----------------------------------------------------------------------------
// ieee_adder_pack: normalize, round-to-nearest-even and pack a binary32 sum.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ieee_adder_pack #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 28
) (
  input  logic                    clock_in,
  input  logic                    rst_n_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    sign_in,
  input  logic signed [EXP_W-1:0] exp_in,
  input  logic [MANT_W-1:0]       mant_in,
  input  logic                    is_nan_in,
  input  logic                    is_inf_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [31:0]             outputC,
  output logic                    overflow_out,
  output logic                    underflow_out,
  output logic                    inexact_out
);

  import ieee754_pkg::*;

  // Two extra exponent bits so +1 / -lz never wrap before the range checks
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);

  logic advance;
  assign advance   = !valid_out || ready_in;
  assign ready_out = advance;

  logic [4:0]               lz;
  logic signed [EW-1:0]     exp_ext;
  logic signed [EW-1:0]     lz_ext;
  logic signed [EW-1:0]     norm_exp;
  logic [HIDDEN_BIT-1:0]    norm_frac;
  cls_t                     cls;

  ieee_lzc27 u_lzc (
    .value (mant_in[HIDDEN_BIT:0]),
    .count (lz)
  );

  assign exp_ext = {{(EW-EXP_W){exp_in[EXP_W-1]}}, exp_in};
  assign lz_ext  = {{(EW-5){1'b0}}, lz};

  // The hidden bit is implicit after normalization, so only [25:0] is kept
  always_comb begin
    norm_frac = '0;
    norm_exp  = exp_ext;
    if (mant_in[CARRY_BIT]) begin
      norm_frac = {mant_in[HIDDEN_BIT:2], mant_in[R_BIT] | mant_in[S_BIT]};
      norm_exp  = exp_ext + E_ONE;
    end else begin
      norm_frac = mant_in[HIDDEN_BIT-1:0] << lz;
      norm_exp  = exp_ext - lz_ext;
    end
  end

  always_comb begin
    cls = CLS_NORM;
    if (is_nan_in)          cls = CLS_NAN;
    else if (is_inf_in)     cls = CLS_INF;
    else if (mant_in == '0) cls = CLS_ZERO;
  end

  logic                  s1_valid;
  logic                  s1_sign;
  cls_t                  s1_cls;
  logic signed [EW-1:0]  s1_exp;
  logic [HIDDEN_BIT-1:0] s1_frac;

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_exp   <= '0;
      s1_frac  <= '0;
    end else if (advance) begin
      s1_valid <= valid_in;
      s1_sign  <= sign_in;
      s1_cls   <= cls;
      s1_exp   <= norm_exp;
      s1_frac  <= norm_frac;
    end
  end

  logic                 round_up;
  logic [FRAC_W:0]      rounded;
  logic signed [EW-1:0] rnd_exp;
  logic [31:0]          res_word;
  logic                 res_ovf;
  logic                 res_unf;
  logic                 res_inx;

  assign round_up = s1_frac[G_BIT] &&
                    (s1_frac[R_BIT] || s1_frac[S_BIT] || s1_frac[LSB_BIT]);
  // A carry out of the fraction means 1.111..1 rounded up to 10.000..0
  assign rounded  = {1'b0, s1_frac[HIDDEN_BIT-1:LSB_BIT]} + {{FRAC_W{1'b0}}, round_up};
  assign rnd_exp  = rounded[FRAC_W] ? s1_exp + E_ONE : s1_exp;

  always_comb begin
    res_word = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_inx  = 1'b0;
    case (s1_cls)
      CLS_NAN:  res_word = QNAN;
      CLS_INF:  res_word = pack_fp(s1_sign, {EXPF_W{1'b1}}, '0);
      CLS_ZERO: res_word = pack_fp(s1_sign, '0, '0);
      CLS_NORM: begin
        if (s1_exp <= E_ZERO) begin
          res_word = pack_fp(s1_sign, '0, '0);
          res_unf  = 1'b1;
          res_inx  = 1'b1;
        end else if (rnd_exp >= E_MAX) begin
          res_word = pack_fp(s1_sign, {EXPF_W{1'b1}}, '0);
          res_ovf  = 1'b1;
          res_inx  = 1'b1;
        end else begin
          res_word = pack_fp(s1_sign, rnd_exp[EXPF_W-1:0], rounded[FRAC_W-1:0]);
          res_inx  = |s1_frac[G_BIT:S_BIT];
        end
      end
      default: res_word = '0;
    endcase
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out     <= 1'b0;
      outputC       <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      inexact_out   <= 1'b0;
    end else if (advance) begin
      valid_out     <= s1_valid;
      outputC       <= s1_valid ? res_word : '0;
      overflow_out  <= s1_valid && res_ovf;
      underflow_out <= s1_valid && res_unf;
      inexact_out   <= s1_valid && res_inx;
    end
  end

endmodule

`default_nettype wire
